p251_add: RTL and testbench

- Registered modular adder over GF(251): out = (in_1 + in_2) mod 251 for 8-bit operands.
- Leaf arithmetic primitive in the common library, used by the SDitH field-arithmetic datapaths (polynomial/MPC share computation).
- Fully pipelined: accepts a new operand pair every clock and returns the result with fixed one-cycle latency.

---
 rtl/p251_add.sv | 49 ++++
 tb/tb_p251_add.sv | 129 ++++++++++++
 2 files changed

// File: rtl/p251_add.sv
// Purpose: registered modular adder over GF(PRIME), out = (in_1 + in_2) mod PRIME.
// Latency: one cycle from i_start to o_done/out; a new operand pair accepted every clock.
// Backpressure: none; every accepted i_start yields exactly one o_done pulse.
module p251_add #(
    parameter int WIDTH = 8,
    parameter int PRIME = 251
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    output logic [WIDTH-1:0] out,
    output logic             o_done
);

    // The sum needs one extra bit; with 2^WIDTH > PRIME, 2*PRIME still fits in WIDTH+1 bits.
    localparam logic [WIDTH:0] PRIME_X1 = (WIDTH+1)'(PRIME);
    localparam logic [WIDTH:0] PRIME_X2 = (WIDTH+1)'(2 * PRIME);

    logic [WIDTH:0] sum_full;
    logic [WIDTH:0] sum_red;

    // Full reduction: non-canonical operands can push the sum past 2*PRIME,
    // so a single conditional subtract of PRIME is not enough.
    always_comb begin
        sum_full = {1'b0, in_1} + {1'b0, in_2};
        sum_red  = sum_full;
        if (sum_full >= PRIME_X2) begin
            sum_red = sum_full - PRIME_X2;
        end else if (sum_full >= PRIME_X1) begin
            sum_red = sum_full - PRIME_X1;
        end
    end

    // Output registers: reset wins over i_start; out holds between strobes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out    <= '0;
            o_done <= 1'b0;
        end else begin
            o_done <= i_start;
            if (i_start) begin
                out <= sum_red[WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_p251_add.sv
// Purpose: scoreboard bench for p251_add; directed plan vectors plus randomized stream.
// Latency: expects o_done/out one clock after each sampled i_start.
// Backpressure: none; every clock's expected output is queued and checked in order.
module tb_p251_add;

    logic       i_clk;
    logic       i_rst;
    logic       i_start;
    logic [7:0] in_1;
    logic [7:0] in_2;
    logic [7:0] out;
    logic       o_done;

    typedef struct {
        logic       done;
        logic [7:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   model_out   = 0;

    p251_add #(.WIDTH(8), .PRIME(251)) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_start(i_start),
        .in_1   (in_1),
        .in_2   (in_2),
        .out    (out),
        .o_done (o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Drive one clock of stimulus and queue the response expected after that edge.
    task automatic step(input logic rst, input logic st, input int a, input int b);
        exp_t e;
        i_rst   = rst;
        i_start = st;
        in_1    = 8'(a);
        in_2    = 8'(b);
        @(posedge i_clk);
        if (rst) begin
            model_out = 0;
            e.done    = 1'b0;
        end else if (st) begin
            model_out = (a + b) % 251;
            e.done    = 1'b1;
        end else begin
            e.done    = 1'b0;
        end
        e.val = 8'(model_out);
        exp_q.push_back(e);
        #1;
    endtask

    // Monitor: compare every queued expectation on the falling edge after it was issued.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (o_done !== e.done || out !== e.val || out > 8'd250) begin
                    miscompares++;
                    $display("FAIL vec%0d: o_done=%0b out=%0d, required o_done=%0b out=%0d (out<=250)",
                             vectors, o_done, out, e.done, e.val);
                end
            end
        end
    end

    initial begin
        int a, b;
        i_rst = 1'b1; i_start = 1'b0; in_1 = '0; in_2 = '0;

        // Reset held with a live strobe: nothing must come out.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 5, 6);
        step(1'b0, 1'b1, 5, 6);
        step(1'b0, 1'b0, 0, 0);

        // Back-to-back stream then idle: out must hold 159.
        step(1'b0, 1'b1, 1, 20);
        step(1'b0, 1'b1, 234, 31);
        step(1'b0, 1'b1, 240, 85);
        step(1'b0, 1'b1, 245, 165);
        step(1'b0, 1'b0, 3, 3);
        step(1'b0, 1'b0, 9, 9);

        // Boundaries and non-canonical operands.
        step(1'b0, 1'b1, 250, 1);
        step(1'b0, 1'b1, 0, 0);
        step(1'b0, 1'b1, 250, 0);
        step(1'b0, 1'b1, 250, 250);
        step(1'b0, 1'b1, 125, 126);
        step(1'b0, 1'b1, 255, 255);
        step(1'b0, 1'b1, 251, 0);
        step(1'b0, 1'b1, 255, 0);
        step(1'b0, 1'b1, 253, 251);

        // Gapped strobes.
        step(1'b0, 1'b1, 100, 200);
        step(1'b0, 1'b0, 77, 66);
        step(1'b0, 1'b1, 7, 8);
        step(1'b0, 1'b0, 1, 1);

        // Randomized stream with a reset burst in the middle.
        for (int i = 0; i < 10000; i++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            step((i >= 5000 && i < 5003) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)), a, b);
        end
        step(1'b0, 1'b0, 0, 0);

        // Bounded drain: all expectations must have been matched by now.
        repeat (3) @(negedge i_clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
